// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a start/busy/done handshake.
// Latency: BIN_W cycles from start acceptance to the done pulse. Backpressure: start is ignored while busy.
module bcd_seq_ctrl #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BIN_W-1:0]  bin_sr;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_adj;
    logic [ACC_W-1:0]  acc_nxt;

    // Add-3 on every digit >= 5, then shift in the next operand bit.
    always_comb begin
        acc_adj = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
        acc_nxt = {acc_adj[ACC_W-2:0], bin_sr[BIN_W-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            bin_sr <= '0;
            acc    <= '0;
            bcd    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                CONV: begin
                    acc    <= acc_nxt;
                    bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd   <= acc_nxt;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept, giving back-to-back conversions.
                    done <= 1'b0;
                    if (start) begin
                        bin_sr <= bin;
                        acc    <= '0;
                        cnt    <= CNT_W'(BIN_W);
                        state  <= CONV;
                        busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Self-checking bench for bcd_seq_ctrl: vector table, corner-case sequences, scoreboard queue and a wide instance.
module tb_bcd_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bin = '0;
    logic        busy, done;
    logic [11:0] bcd;

    logic        start_w = 1'b0;
    logic [11:0] bin_w = '0;
    logic        busy_w, done_w;
    logic [15:0] bcd_w;

    int total = 0;
    int bad = 0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    bcd_seq_ctrl #(.BIN_W(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd)
    );

    bcd_seq_ctrl #(.BIN_W(12), .DIGITS(4)) u_wide (
        .clk(clk), .rst_n(rst_n), .start(start_w), .bin(bin_w),
        .busy(busy_w), .done(done_w), .bcd(bcd_w)
    );

    typedef struct {
        logic [7:0]  b;
        logic [11:0] exp;
    } vec_t;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_exp(output logic [15:0] e);
        if (sb_q.size() == 0) begin
            e = 16'hxxxx;
            $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
            bad++;
            total++;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    // Called at the first negedge after acceptance; returns cycles until done is seen.
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic run_one(input string name, input logic [7:0] b);
        int lat;
        logic [15:0] e;
        @(negedge clk);
        start = 1'b1;
        bin = b;
        sb_q.push_back(ref_bcd(int'(b)));
        @(negedge clk);
        start = 1'b0;
        bin = 8'($urandom);
        check({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(name, lat);
        pop_exp(e);
        check({name, "_lat"}, 32'(lat), 32'd8);
        check({name, "_bcd"}, 32'(bcd), 32'(e[11:0]));
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t tbl[4];
        int lat;
        int dcnt;
        logic [15:0] e;

        tbl[0] = '{b: 8'd0,   exp: 12'h000};
        tbl[1] = '{b: 8'd255, exp: 12'h255};
        tbl[2] = '{b: 8'd100, exp: 12'h100};
        tbl[3] = '{b: 8'd99,  exp: 12'h099};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven basic conversions
        for (int i = 0; i < 4; i++) begin
            run_one($sformatf("vec%0d", i), tbl[i].b);
            check($sformatf("vec%0d_table", i), 32'(bcd), 32'(tbl[i].exp));
        end

        // Back-to-back start at the done cycle
        @(negedge clk);
        start = 1'b1; bin = 8'd128; sb_q.push_back(16'h0128);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_a", lat);
        pop_exp(e);
        check("b2b_a_lat", 32'(lat), 32'd8);
        check("b2b_a_bcd", 32'(bcd), 32'(e[11:0]));
        start = 1'b1; bin = 8'd37; sb_q.push_back(16'h0037);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_gap_busy", 32'(busy), 32'd1);
        check("b2b_hold_bcd", 32'(bcd), 32'h128);
        wait_done("b2b_b", lat);
        pop_exp(e);
        check("b2b_b_lat", 32'(lat), 32'd8);
        check("b2b_b_bcd", 32'(bcd), 32'(e[11:0]));

        // Start during CONV is ignored
        @(negedge clk);
        start = 1'b1; bin = 8'd200; sb_q.push_back(16'h0200);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; bin = 8'd5;
        @(negedge clk);
        start = 1'b0;
        check("ign_bcd_stable", 32'(bcd), 32'h037);
        wait_done("ign", lat);
        pop_exp(e);
        check("ign_lat", 32'(lat), 32'd4);
        check("ign_bcd", 32'(bcd), 32'(e[11:0]));
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("ign_single_done", 32'(dcnt), 32'd0);

        // Reset mid-conversion
        start = 1'b1; bin = 8'd77;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_bcd", 32'(bcd), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("arst_no_done", 32'(dcnt), 32'd0);
        run_one("post_rst", 8'd9);

        // Wide instance: 12-bit operand, 4 digits
        @(negedge clk);
        start_w = 1'b1; bin_w = 12'd4095;
        @(negedge clk);
        start_w = 1'b0;
        lat = 0;
        while (!done_w && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("wide_lat", 32'(lat), 32'd12);
        check("wide_bcd", 32'(bcd_w), 32'h4095);

        // Exhaustive sweep with start held high
        @(negedge clk);
        start = 1'b1; bin = 8'd0; sb_q.push_back(ref_bcd(0));
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            wait_done($sformatf("sweep%0d", v), lat);
            pop_exp(e);
            if (lat != 8 || bcd !== e[11:0]) begin
                check($sformatf("sweep%0d_lat", v), 32'(lat), 32'd8);
                check($sformatf("sweep%0d_bcd", v), 32'(bcd), 32'(e[11:0]));
            end else begin
                total++;
            end
            if (v < 255) begin
                bin = 8'(v + 1);
                sb_q.push_back(ref_bcd(v + 1));
            end else begin
                start = 1'b0;
            end
        end
        check("sweep_q_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
